// File: rtl/accel_onchip_memory_dp_pkg.sv
// Shared constants and elaboration helpers for the dual-port on-chip memory.
// Holds the read-latency function and the parameter-legality check.
package accel_mem_pkg;

  localparam int COLL_W = 16;

  function automatic int lat(input int outreg);
    return 1 + outreg;
  endfunction

  function automatic bit params_ok(input int data_w, input int addr_w,
                                   input int depth, input int outreg);
    return (data_w > 0) && (data_w % 8 == 0) && (addr_w > 0) && (addr_w < 32) &&
           (depth > 0) && (longint'(depth) <= (longint'(1) << addr_w)) &&
           ((outreg == 0) || (outreg == 1));
  endfunction

endpackage

// File: rtl/accel_onchip_memory_dp_if.sv
// Avalon-MM pipelined slave bundle; one instance per memory port.
// Master drives requests, the slave returns readdata/readdatavalid/waitrequest.
interface accel_onchip_memory_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/accel_onchip_memory_dp_ram.sv
// True-dual-port byte-enabled RAM, read-first on both ports, 1-cycle registered read.
// No reset on contents or read registers; read registers hold when their read enable is low.
module accel_tdp_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 16,
  parameter int DEPTH  = 37500,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_a_re,
  input  logic [BE_W-1:0]   i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_q,
  input  logic              i_b_re,
  input  logic [BE_W-1:0]   i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_q
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Reads sample the array before this edge's writes land, giving old data on any overlap.
  always_ff @(posedge clk) begin
    if (i_a_re) o_a_q <= r_mem[i_a_addr];
    if (i_b_re) o_b_q <= r_mem[i_b_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (i_a_we[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
      if (i_b_we[i]) r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
    end
  end
endmodule

// File: rtl/accel_onchip_memory_dp.sv
// Two Avalon-MM slaves onto one TDP RAM; read latency 1+OUTREG, pipelined one read/cycle/port.
// waitrequest = ~clken | reset_req; stages only advance on clken, so responses hold while stalled.
module accel_onchip_memory_dp
  import accel_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 37500,
  parameter int OUTREG = 0,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  accel_onchip_memory_dp_if.slave s1,
  accel_onchip_memory_dp_if.slave s2,
  output logic [COLL_W-1:0]       collision_cnt,
  output logic                    oor_flag,
  input  logic                    oor_clear
);
  localparam int              RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              LAT     = lat(OUTREG);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  if (!params_ok(DATA_W, ADDR_W, DEPTH, OUTREG) || (BE_W != DATA_W / 8)) begin : g_param_err
    $error("accel_onchip_memory_dp: illegal parameter combination");
  end

  logic                   w_wait;
  logic [1:0]             w_req, w_wr, w_rd, w_inr, w_re;
  logic [1:0][ADDR_W-1:0] w_addr;
  logic                   w_coll, w_oor_evt;
  logic [BE_W-1:0]        w_we1, w_we2;
  logic [1:0][DATA_W-1:0] w_q, w_d1, w_rdd;
  logic [1:0]             w_rdv;
  logic [1:0]             r_v1, r_ok1;

  assign w_wait         = ~clken | reset_req;
  assign s1.waitrequest = w_wait;
  assign s2.waitrequest = w_wait;

  // read+write together is taken as a write and never produces a response
  assign w_addr = {s2.address, s1.address};
  assign w_req  = {s2.chipselect & (s2.read | s2.write),
                   s1.chipselect & (s1.read | s1.write)} & {2{~w_wait}};
  assign w_wr   = w_req & {s2.write, s1.write};
  assign w_rd   = w_req & {s2.read & ~s2.write, s1.read & ~s1.write};

  always_comb begin
    w_inr = '0;
    for (int i = 0; i < 2; i++) w_inr[i] = ({1'b0, w_addr[i]} < DEPTH_V);
  end

  assign w_coll    = &w_wr & (s1.address == s2.address);
  assign w_oor_evt = |(w_req & ~w_inr);
  assign w_re      = w_rd & w_inr;
  assign w_we1     = (w_wr[0] & w_inr[0]) ? s1.byteenable : '0;
  assign w_we2     = (w_wr[1] & w_inr[1] & ~w_coll) ? s2.byteenable : '0;

  accel_tdp_ram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_a_re    (w_re[0]),
    .i_a_we    (w_we1),
    .i_a_addr  (s1.address[RAM_AW-1:0]),
    .i_a_wdata (s1.writedata),
    .o_a_q     (w_q[0]),
    .i_b_re    (w_re[1]),
    .i_b_we    (w_we2),
    .i_b_addr  (s2.address[RAM_AW-1:0]),
    .i_b_wdata (s2.writedata),
    .o_b_q     (w_q[1])
  );

  // r_ok1 records whether the RAM register holds the latest response (0 after reset or an OOR read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1  <= '0;
      r_ok1 <= '0;
    end else if (clken) begin
      r_v1 <= w_rd;
      for (int i = 0; i < 2; i++) if (w_rd[i]) r_ok1[i] <= w_inr[i];
    end
  end

  always_comb begin
    w_d1 = '0;
    for (int i = 0; i < 2; i++) w_d1[i] = r_ok1[i] ? w_q[i] : '0;
  end

  if (LAT == 2) begin : g_outreg
    logic [1:0]             r_v2;
    logic [1:0][DATA_W-1:0] r_d2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v2 <= '0;
        r_d2 <= '0;
      end else if (clken) begin
        r_v2 <= r_v1;
        for (int i = 0; i < 2; i++) if (r_v1[i]) r_d2[i] <= w_d1[i];
      end
    end

    assign w_rdv = r_v2;
    assign w_rdd = r_d2;
  end else begin : g_direct
    assign w_rdv = r_v1;
    assign w_rdd = w_d1;
  end

  assign s1.readdatavalid = w_rdv[0];
  assign s1.readdata      = w_rdd[0];
  assign s2.readdatavalid = w_rdv[1];
  assign s2.readdata      = w_rdd[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_cnt <= '0;
      oor_flag      <= 1'b0;
    end else begin
      if (w_coll && (collision_cnt != '1)) collision_cnt <= collision_cnt + 1'b1;
      if (w_oor_evt)      oor_flag <= 1'b1;
      else if (oor_clear) oor_flag <= 1'b0;
    end
  end
endmodule

// File: doc/accel_onchip_memory_dp.md
Name: accel_onchip_memory_dp

Overview:
Parametrised dual-port successor to the accelerator's single-port on-chip RAM. It exposes two independent Avalon-MM pipelined slaves (s1, s2) onto one true-dual-port block RAM. It adds configurable width, depth and read latency, and generates readdatavalid and waitrequest. It detects write-write collisions and out-of-range accesses. It sits between the accelerator datapath (s2) and the host interconnect (s1).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 16, word-address width
DEPTH, 37500, words implemented; must be ≤ 2**ADDR_W
OUTREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
BE_W, DATA_W/8, derived value; must not be overridden

Ports:
clk  in  1  single clock for both ports
reset  in  1  asynchronous, active-high reset
clken  in  1  global clock enable
reset_req  in  1  reset-request; holds off all accesses while high
s1_address  in  ADDR_W  port-1 word address
s1_byteenable  in  BE_W  port-1 byte lanes
s1_chipselect  in  1  port-1 select
s1_read  in  1  port-1 read request
s1_write  in  1  port-1 write request
s1_writedata  in  DATA_W  port-1 write data
s1_readdata  out  DATA_W  port-1 read data
s1_readdatavalid  out  1  port-1 read data valid
s1_waitrequest  out  1  port-1 stall
s2_*  (same set as s1, same widths)  port 2
collision_cnt  out  16  saturating count of same-address write-write collisions
oor_flag  out  1  sticky flag: an access hit an address ≥ DEPTH
oor_clear  in  1  clears oor_flag

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset values: readdata 0, readdatavalid 0, collision_cnt 0, oor_flag 0, all pipeline valid bits 0. RAM contents are not reset.
- waitrequest (both ports) = ~clken | reset_req, combinational.
- Accept: chipselect & (read | write) & ~waitrequest. read & write together in one cycle is illegal; treat it as a write and issue no readdatavalid.
- Write: bytes with byteenable=1 are written at the accepting edge. A write with byteenable=0 is a no-op.
- Read: readdatavalid is asserted exactly 1+OUTREG cycles after acceptance. Reads are fully pipelined, one per cycle per port.
- Pipeline stages advance only when clken=1. While clken=0, readdata and readdatavalid hold their values, and a valid already presented stays asserted.
- Each read response is delivered exactly once, on the first clken=1 edge at which its stage retires.
- readdata keeps its last value when readdatavalid=0; it is not zeroed.
- Same-port read-during-write: read-first (returns old data).
- Mixed-port read of an address being written by the other port in the same cycle: returns old data.
- Write-write collision (both ports write the same address in the same cycle): s1 wins for all bytes. s2's write is dropped entirely. collision_cnt increments by 1 and saturates at 0xFFFF. A collision is counted even when the byte-enables do not overlap.
- Out-of-range (address ≥ DEPTH): the write is ignored. A read still produces readdatavalid at normal latency with readdata=0. oor_flag is set.
- oor_flag: oor_clear in the same cycle as a new out-of-range event leaves the flag set (set wins).
- reset asserted mid-read discards in-flight responses; none are issued after reset deasserts.
- reset_req high holds waitrequest and blocks new accepts. In-flight reads still complete.

Decomposition:
- Package accel_mem_pkg: collision-counter width (16), latency function lat(OUTREG) = 1+OUTREG, and a parameter-legality check (DATA_W%8, DEPTH ≤ 2**ADDR_W).
- Sub-module accel_tdp_ram: inferred true-dual-port RAM with byte enables and read-first behaviour, no reset. Collision arbitration, the valid pipeline, OUTREG staging and status logic stay in the top level.

Test Plan:
- OUTREG=0: s1 writes 0xDEADBEEF @0x10 with BE=0xF, then s1 reads 0x10 → s1_readdatavalid exactly 1 cycle after accept, data 0xDEADBEEF. Repeat with OUTREG=1 → valid after 2 cycles.
- Byte lanes: write 0x11223344 @5, then s2 writes 0xAABBCCDD BE=0b0101 @5, then read @5 → 0x11BB33DD.
- Collision: s1 writes 0x1 and s2 writes 0x2 to @7 in the same cycle → read @7 = 0x1 and collision_cnt=1. Repeat 70000 times → collision_cnt=0xFFFF.
- Back-to-back reads on both ports to @0..@3 with clken dropped for 3 cycles mid-burst → 4 responses per port, in order, none duplicated or lost; waitrequest=1 exactly while clken=0.
- Out-of-range read @37500 → readdatavalid with data 0, oor_flag=1. Write @40000 then read @40000 → 0. oor_clear with a simultaneous out-of-range read → flag stays 1.
- Reset asserted 1 cycle after a read accept with OUTREG=1 → no readdatavalid afterwards; outputs 0 immediately (asynchronous); RAM contents preserved on a subsequent read.
